// File: rtl/univ_shift_reg.sv
// Universal shift register: hold/shift/rotate/load/clear plus a self-timed serialiser.
// Latency: mode ops take effect at the next edge; a serial word takes WIDTH edges after start.
// No backpressure: start and mode are ignored while busy or during the done cycle.
module univ_shift_reg #(
   parameter int WIDTH     = 4,
   parameter bit MSB_FIRST = 1'b1
) (
   input  logic             clk,
   input  logic             clr,
   input  logic [2:0]       mode,
   input  logic [WIDTH-1:0] d,
   input  logic             sin,
   input  logic             start,
   output logic [WIDTH-1:0] q,
   output logic             sout,
   output logic             busy,
   output logic             done
);

   localparam int CW = $clog2(WIDTH + 1);

   typedef enum logic [1:0] {IDLE, XFER, DONE} state_t;

   state_t           state, state_nxt;
   logic [CW-1:0]    cnt, cnt_nxt;
   logic [WIDTH-1:0] q_nxt;
   logic             sout_nxt, busy_nxt, done_nxt;

   always_ff @(posedge clk) begin
      if (!clr) begin
         state <= IDLE;
         cnt   <= '0;
         q     <= '0;
         sout  <= 1'b0;
         busy  <= 1'b0;
         done  <= 1'b0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
         q     <= q_nxt;
         sout  <= sout_nxt;
         busy  <= busy_nxt;
         done  <= done_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      q_nxt     = q;
      sout_nxt  = sout;
      busy_nxt  = busy;
      done_nxt  = 1'b0;
      case (state)
         IDLE: begin
            if (start) begin
               q_nxt     = d;
               cnt_nxt   = '0;
               busy_nxt  = 1'b1;
               state_nxt = XFER;
            end else begin
               case (mode)
                  3'b001: begin
                     q_nxt    = {sin, q[WIDTH-1:1]};
                     sout_nxt = q[0];
                  end
                  3'b010: begin
                     q_nxt    = {q[WIDTH-2:0], sin};
                     sout_nxt = q[WIDTH-1];
                  end
                  3'b011: q_nxt = d;
                  3'b100: begin
                     q_nxt    = {q[0], q[WIDTH-1:1]};
                     sout_nxt = q[0];
                  end
                  3'b101: begin
                     q_nxt    = {q[WIDTH-2:0], q[WIDTH-1]};
                     sout_nxt = q[WIDTH-1];
                  end
                  3'b110: q_nxt = '0;
                  default: q_nxt = q;
               endcase
            end
         end
         XFER: begin
            if (MSB_FIRST) begin
               q_nxt    = {q[WIDTH-2:0], sin};
               sout_nxt = q[WIDTH-1];
            end else begin
               q_nxt    = {sin, q[WIDTH-1:1]};
               sout_nxt = q[0];
            end
            cnt_nxt = cnt + CW'(1);
            // This edge moves the last bit out, so the counter reaches WIDTH here.
            if (cnt == CW'(WIDTH - 1)) begin
               state_nxt = DONE;
               busy_nxt  = 1'b0;
               done_nxt  = 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

endmodule

// File: tb/tb_univ_shift_reg.sv
// Bench for univ_shift_reg: MSB-first and LSB-first instances share all inputs and are checked
// against directed tables, hand-written serialiser sequences and a per-cycle behavioural model.
module tb_univ_shift_reg;

   localparam int W = 4;

   logic         clk = 1'b0;
   logic         clr = 1'b0;
   logic [2:0]   mode = 3'd0;
   logic [W-1:0] d = '0;
   logic         sin = 1'b0;
   logic         start = 1'b0;

   logic [W-1:0] q0, q1;
   logic         sout0, sout1, busy0, busy1, done0, done1;

   int ntot = 0;
   int npass = 0;

   // index 0 models the MSB-first instance, index 1 the LSB-first one
   logic [W-1:0] mq[2];
   logic         msout[2];
   logic         mbusy[2];
   logic         mdone[2];
   int           mleft[2];

   always #5 clk = ~clk;

   univ_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b1)) u_msb (
      .clk(clk), .clr(clr), .mode(mode), .d(d), .sin(sin), .start(start),
      .q(q0), .sout(sout0), .busy(busy0), .done(done0)
   );

   univ_shift_reg #(.WIDTH(W), .MSB_FIRST(1'b0)) u_lsb (
      .clk(clk), .clr(clr), .mode(mode), .d(d), .sin(sin), .start(start),
      .q(q1), .sout(sout1), .busy(busy1), .done(done1)
   );

   task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
      ntot++;
      if (got === exp) npass++;
      else $display("FAIL %s: got %0h expected %0h", name, got, exp);
   endtask

   task automatic model_step(input logic c, input logic [2:0] m, input logic [W-1:0] dv,
                             input logic s, input logic st);
      logic [31:0] v, top, low, msk, sv;
      msk = (32'd1 << W) - 32'd1;
      sv  = 32'(s);
      for (int i = 0; i < 2; i++) begin
         v   = 32'(mq[i]);
         top = (v >> (W - 1)) & 32'd1;
         low = v & 32'd1;
         if (!c) begin
            v = 0; msout[i] = 1'b0; mbusy[i] = 1'b0; mdone[i] = 1'b0; mleft[i] = 0;
         end else if (mdone[i]) begin
            mdone[i] = 1'b0;
         end else if (mbusy[i]) begin
            if (i == 0) begin
               msout[i] = top[0];
               v = ((v << 1) | sv) & msk;
            end else begin
               msout[i] = low[0];
               v = (v >> 1) | (sv << (W - 1));
            end
            mleft[i]--;
            if (mleft[i] == 0) begin
               mbusy[i] = 1'b0;
               mdone[i] = 1'b1;
            end
         end else if (st) begin
            v = 32'(dv); mbusy[i] = 1'b1; mleft[i] = W;
         end else begin
            case (m)
               3'd1: begin msout[i] = low[0]; v = (v >> 1) | (sv << (W - 1)); end
               3'd2: begin msout[i] = top[0]; v = ((v << 1) | sv) & msk; end
               3'd3: v = 32'(dv);
               3'd4: begin msout[i] = low[0]; v = (v >> 1) | (low << (W - 1)); end
               3'd5: begin msout[i] = top[0]; v = ((v << 1) | top) & msk; end
               3'd6: v = 0;
               default: ;
            endcase
         end
         mq[i] = v[W-1:0];
      end
   endtask

   task automatic cyc(input logic c, input logic [2:0] m, input logic [W-1:0] dv,
                      input logic s, input logic st);
      clr = c; mode = m; d = dv; sin = s; start = st;
      @(posedge clk);
      model_step(c, m, dv, s, st);
      #1;
      chk("model q msb", 32'(q0), 32'(mq[0]));
      chk("model q lsb", 32'(q1), 32'(mq[1]));
      chk("model sout msb", 32'(sout0), 32'(msout[0]));
      chk("model sout lsb", 32'(sout1), 32'(msout[1]));
      chk("model busy msb", 32'(busy0), 32'(mbusy[0]));
      chk("model busy lsb", 32'(busy1), 32'(mbusy[1]));
      chk("model done msb", 32'(done0), 32'(mdone[0]));
      chk("model done lsb", 32'(done1), 32'(mdone[1]));
   endtask

   // d=1011 goes out as 1,0,1,1 MSB-first and 1,1,0,1 LSB-first (listed from bit 3 down)
   task automatic serial_run(input logic ign, input string tag);
      logic [3:0] ea, eb;
      ea = 4'b1011;
      eb = 4'b1101;
      cyc(1'b1, 3'd0, 4'b1011, 1'b0, 1'b1);
      chk({tag, " E0 busy"}, 32'(busy0), 32'd1);
      chk({tag, " E0 q"}, 32'(q0), 32'hb);
      chk({tag, " E0 done"}, 32'(done0), 32'd0);
      for (int k = 0; k < 4; k++) begin
         if (ign) cyc(1'b1, 3'b110, 4'b0000, 1'b0, 1'b1);
         else     cyc(1'b1, 3'b000, 4'b0000, 1'b0, 1'b0);
         chk({tag, " sout msb"}, 32'(sout0), 32'(ea[3-k]));
         chk({tag, " sout lsb"}, 32'(sout1), 32'(eb[3-k]));
         chk({tag, " busy"}, 32'(busy0), 32'(k < 3));
         chk({tag, " done"}, 32'(done0), 32'(k == 3));
      end
      if (ign) cyc(1'b1, 3'b011, 4'b1111, 1'b0, 1'b1);
      else     cyc(1'b1, 3'b000, 4'b0000, 1'b0, 1'b0);
      chk({tag, " post done"}, 32'(done0), 32'd0);
      chk({tag, " post busy"}, 32'(busy0), 32'd0);
      chk({tag, " post q msb"}, 32'(q0), 32'd0);
      chk({tag, " post q lsb"}, 32'(q1), 32'd0);
   endtask

   typedef struct {
      logic         c;
      logic [2:0]   m;
      logic [W-1:0] dv;
      logic         s;
      logic [W-1:0] eq;
      logic         esout;
   } vec_t;

   vec_t tbl[16];

   initial begin
      logic         rc, rs, rst;
      logic [2:0]   rm;
      logic [W-1:0] rd;

      for (int i = 0; i < 2; i++) begin
         mq[i] = '0; msout[i] = 1'b0; mbusy[i] = 1'b0; mdone[i] = 1'b0; mleft[i] = 0;
      end

      tbl[0]  = '{1'b0, 3'b000, 4'b0000, 1'b0, 4'b0000, 1'b0};
      tbl[1]  = '{1'b0, 3'b011, 4'b1111, 1'b1, 4'b0000, 1'b0};
      tbl[2]  = '{1'b1, 3'b000, 4'b1111, 1'b1, 4'b0000, 1'b0};
      tbl[3]  = '{1'b1, 3'b011, 4'b1010, 1'b0, 4'b1010, 1'b0};
      tbl[4]  = '{1'b1, 3'b001, 4'b0000, 1'b1, 4'b1101, 1'b0};
      tbl[5]  = '{1'b1, 3'b011, 4'b1010, 1'b0, 4'b1010, 1'b0};
      tbl[6]  = '{1'b1, 3'b010, 4'b0000, 1'b0, 4'b0100, 1'b1};
      tbl[7]  = '{1'b1, 3'b011, 4'b0001, 1'b0, 4'b0001, 1'b1};
      tbl[8]  = '{1'b1, 3'b100, 4'b0000, 1'b0, 4'b1000, 1'b1};
      tbl[9]  = '{1'b1, 3'b100, 4'b0000, 1'b0, 4'b0100, 1'b0};
      tbl[10] = '{1'b1, 3'b011, 4'b1000, 1'b0, 4'b1000, 1'b0};
      tbl[11] = '{1'b1, 3'b101, 4'b0000, 1'b0, 4'b0001, 1'b1};
      tbl[12] = '{1'b1, 3'b011, 4'b0110, 1'b0, 4'b0110, 1'b1};
      tbl[13] = '{1'b1, 3'b111, 4'b1111, 1'b1, 4'b0110, 1'b1};
      tbl[14] = '{1'b1, 3'b110, 4'b1111, 1'b1, 4'b0000, 1'b1};
      tbl[15] = '{1'b1, 3'b000, 4'b1111, 1'b1, 4'b0000, 1'b1};

      for (int i = 0; i < 16; i++) begin
         cyc(tbl[i].c, tbl[i].m, tbl[i].dv, tbl[i].s, 1'b0);
         chk($sformatf("vec%0d q msb", i), 32'(q0), 32'(tbl[i].eq));
         chk($sformatf("vec%0d q lsb", i), 32'(q1), 32'(tbl[i].eq));
         chk($sformatf("vec%0d sout", i), 32'(sout0), 32'(tbl[i].esout));
         chk($sformatf("vec%0d busy", i), 32'(busy0), 32'd0);
         chk($sformatf("vec%0d done", i), 32'(done0), 32'd0);
      end

      serial_run(1'b0, "ser");
      serial_run(1'b1, "ser ignore");

      // abort with reset at E2, then a fresh start right after release
      cyc(1'b1, 3'd0, 4'b1011, 1'b0, 1'b1);
      cyc(1'b1, 3'd0, 4'b0000, 1'b0, 1'b0);
      cyc(1'b0, 3'd0, 4'b0000, 1'b0, 1'b0);
      chk("abort q", 32'(q0), 32'd0);
      chk("abort busy", 32'(busy0), 32'd0);
      chk("abort done", 32'(done0), 32'd0);
      chk("abort sout", 32'(sout0), 32'd0);
      cyc(1'b1, 3'd0, 4'b0000, 1'b0, 1'b0);
      chk("abort no done", 32'(done0), 32'd0);
      cyc(1'b1, 3'd0, 4'b0110, 1'b0, 1'b1);
      chk("restart busy", 32'(busy0), 32'd1);
      chk("restart q", 32'(q1), 32'h6);
      for (int k = 0; k < 5; k++) cyc(1'b1, 3'd0, 4'b0000, 1'b1, 1'b0);

      for (int n = 0; n < 600; n++) begin
         rc  = ($urandom_range(0, 49) != 0);
         rm  = 3'($urandom_range(0, 7));
         rd  = 4'($urandom);
         rs  = 1'($urandom);
         rst = ($urandom_range(0, 5) == 0);
         cyc(rc, rm, rd, rs, rst);
      end

      $display("%0d/%0d checks passed", npass, ntot);
      $finish;
   end

endmodule

// File: doc/univ_shift_reg.md
Name: univ_shift_reg

Overview:
Parametrised universal shift register. It generalises the fixed 4-bit parallel-in/parallel-out register to any WIDTH and adds these functions:
- mode-selected hold, shift, rotate, load and clear
- serial in and serial out
- a self-timed serialiser that loads a word and shifts it out over WIDTH cycles, with a busy/done handshake

It is used as a general data/serial-conversion register in the sequential library.

Parameters:
WIDTH, 4, register width in bits; legal values are WIDTH >= 2.
MSB_FIRST, 1, serialiser direction: 1 = shift left with the MSB out first; 0 = shift right with the LSB out first.

Ports:
clk  input  1  clock; all state changes on the rising edge.
clr  input  1  synchronous active-low reset; clr=0 at a rising edge resets all state.
mode  input  3  operation select; sampled only while the serialiser is idle.
d  input  WIDTH  parallel load data.
sin  input  1  serial input bit for shift modes and for the serialiser fill.
start  input  1  serialiser start request; sampled only in IDLE.
q  output  WIDTH  register contents.
sout  output  1  registered copy of the last bit shifted or rotated out.
busy  output  1  high while the serialiser is transferring.
done  output  1  one-cycle pulse after the last serial bit.

Behaviour:
- Reset (clr=0 at posedge): q=0, sout=0, busy=0, done=0, FSM=IDLE, bit counter=0.
  - Reset overrides start and mode in the same cycle.
  - Reset mid-transfer aborts the transfer immediately; no done pulse is issued.
- Mode encoding (IDLE with start=0, effective at the next edge):
  - 000 hold.
  - 001 shift right: q <= {sin, q[W-1:1]}, sout <= q[0].
  - 010 shift left: q <= {q[W-2:0], sin}, sout <= q[W-1].
  - 011 parallel load: q <= d; sout holds.
  - 100 rotate right: q <= {q[0], q[W-1:1]}, sout <= q[0].
  - 101 rotate left: q <= {q[W-2:0], q[W-1]}, sout <= q[W-1].
  - 110 clear: q <= 0; sout holds.
  - 111 reserved; behaves as hold.
- FSM states: IDLE, XFER, DONE.
  - IDLE and start=1 at edge E0:
    - q <= d, counter <= 0, FSM -> XFER.
    - busy=1 from E0 onward.
    - start has priority over mode.
  - XFER, at each edge E1..EW:
    - MSB_FIRST=1: shift left with sin into the LSB; sout <= q[W-1].
    - MSB_FIRST=0: shift right with sin into the MSB; sout <= q[0].
    - counter increments each edge.
    - At edge EW (counter reaches W): FSM -> DONE, busy <= 0, done <= 1.
  - DONE: lasts one cycle, then FSM -> IDLE and done <= 0.
    - start and mode are ignored in the DONE cycle.
- Handshake rules:
  - busy is high for exactly WIDTH cycles.
  - mode and start are ignored while busy=1 or in DONE.
  - Bit k (k = 0..W-1, counted in transfer order) appears on sout after edge E(k+1).
- Counter width is $clog2(WIDTH+1). It never wraps during a legal transfer.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- WIDTH=4, after reset: clr=0 for 2 edges -> q=0000, sout=0, busy=0, done=0. Release clr, mode=000 -> q stays 0000.
- Load d=1010 (mode 011), then:
  - mode 001 with sin=1 -> q=1101, sout=0.
  - reload 1010, mode 010 with sin=0 -> q=0100, sout=1.
- Rotate: load 0001.
  - mode 100 -> q=1000, then 0100 on successive edges; sout=1, then 0.
  - mode 101 from 1000 -> q=0001.
- Serialiser, MSB_FIRST=1: d=1011, start pulsed in IDLE, sin=0.
  - sout after E1..E4 = 1,0,1,1.
  - busy high E0..E4, done=1 for exactly one cycle after E4, q=0000 at the end.
  - A repeat with MSB_FIRST=0 yields 1,1,0,1.
- Ignore rules: start=1 and mode=110 asserted during XFER -> no restart, q not cleared, sout sequence unchanged. start during the DONE cycle is ignored.
- Reset mid-transfer: clr=0 at E2 -> q=0000, busy=0, done=0, FSM=IDLE. No done pulse follows, and a new start is accepted right after release.
